// File: rtl/sort_pkt_dir_pkg.sv
// Shared types and defaults for the direction-aware packet sorter.
package sort_pkt_dir_pkg;

    localparam int unsigned DEF_DWIDTH      = 8;
    localparam int unsigned DEF_MAX_PKT_LEN = 1024;

    // Top-level FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SORT = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SORT = ST_SORT,
        SEND = ST_SEND
    } state_e;

    // Sort-phase encodings: read first word, read next word, compare/write, flush carry
    localparam logic [1:0] PH_RD_A = 2'd0;
    localparam logic [1:0] PH_RD_B = 2'd1;
    localparam logic [1:0] PH_CMP  = 2'd2;
    localparam logic [1:0] PH_WR   = 2'd3;

    typedef enum logic [1:0] {
        RD_A = PH_RD_A,
        RD_B = PH_RD_B,
        CMP  = PH_CMP,
        WR   = PH_WR
    } phase_e;

endpackage

// File: rtl/sort_pkt_dir_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
module sort_pkt_dir_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; read data holds when re_i is low
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/sort_pkt_dir.sv
// Packet sorter: buffers one Avalon-ST packet, bubble-sorts it in the chosen
// direction, then streams it out with backpressure.
// Optional macro SORT_PKT_DIR_STATS_EN adds packet/truncation counters.
module sort_pkt_dir
    import sort_pkt_dir_pkg::*;
#(
    parameter int unsigned DWIDTH      = DEF_DWIDTH,
    parameter int unsigned MAX_PKT_LEN = DEF_MAX_PKT_LEN
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    input  logic              snk_descend_i,
    output logic              snk_ready_o,
    input  logic              src_ready_i,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_error_o,
    output logic              src_valid_o
`ifdef SORT_PKT_DIR_STATS_EN
    ,
    output logic [31:0]       stat_pkt_cnt_o,
    output logic [15:0]       stat_ovf_cnt_o
`endif
);

    localparam int unsigned AW  = $clog2(MAX_PKT_LEN) + 1;
    localparam int unsigned RAW = AW - 1;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [AW-1:0]     len_q, len_d;
    logic              desc_q, desc_d;
    logic              ovf_q, ovf_d;
    logic [RAW-1:0]    idx_q, idx_d;
    logic [RAW-1:0]    hi_q, hi_d;
    logic [DWIDTH-1:0] carry_q, carry_d;
    logic              swapped_q, swapped_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     out_idx_q, out_idx_d;
    logic              pend_q, pend_d;
    logic              snk_ready_q, snk_ready_d;
    logic              src_valid_q, src_valid_d;
    logic [DWIDTH-1:0] src_data_q, src_data_d;
    logic              src_sop_q, src_sop_d;
    logic              src_eop_q, src_eop_d;
    logic              src_err_q, src_err_d;

    logic              ram_we, ram_re;
    logic [RAW-1:0]    ram_waddr, ram_raddr;
    logic [DWIDTH-1:0] ram_wdata, ram_rdata;
    logic              swap, out_free, src_fire;

    sort_pkt_dir_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .ADDR_W (RAW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Next-state, datapath and buffer-port control
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        len_d       = len_q;
        desc_d      = desc_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        carry_d     = carry_q;
        swapped_d   = swapped_q;
        rd_ptr_d    = rd_ptr_q;
        out_idx_d   = out_idx_q;
        pend_d      = pend_q;
        src_valid_d = src_valid_q;
        src_data_d  = src_data_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_err_d   = src_err_q;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        ram_raddr   = '0;
        swap        = 1'b0;
        out_free    = !src_valid_q || src_ready_i;
        src_fire    = src_valid_q && src_ready_i;

        case (state_q)
            IDLE: begin
                rd_ptr_d  = '0;
                out_idx_d = '0;
                pend_d    = 1'b0;
                if (snk_valid_i && snk_startofpacket_i) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    ram_wdata = snk_data_i;
                    len_d     = AW'(1);
                    desc_d    = snk_descend_i;
                    ovf_d     = 1'b0;
                    state_d   = snk_endofpacket_i ? SEND : LOAD;
                end
            end

            LOAD: begin
                if (snk_valid_i) begin
                    if (snk_startofpacket_i) begin
                        // Restart: previous partial packet is abandoned
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                        ram_wdata = snk_data_i;
                        len_d     = AW'(1);
                        desc_d    = snk_descend_i;
                        ovf_d     = 1'b0;
                    end else if (len_q == AW'(MAX_PKT_LEN)) begin
                        ovf_d = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = len_q[RAW-1:0];
                        ram_wdata = snk_data_i;
                        len_d     = len_q + AW'(1);
                    end
                    if (snk_endofpacket_i) begin
                        if (len_d == AW'(1)) begin
                            state_d = SEND;
                        end else begin
                            state_d   = SORT;
                            phase_d   = RD_A;
                            idx_d     = '0;
                            hi_d      = RAW'(len_d - AW'(1));
                            swapped_d = 1'b0;
                        end
                    end
                end
            end

            SORT: begin
                // The running extreme rides in carry, so each compare costs one read and one write
                case (phase_q)
                    RD_A: begin
                        ram_re    = 1'b1;
                        ram_raddr = '0;
                        phase_d   = RD_B;
                    end
                    RD_B: begin
                        if (idx_q == '0) begin
                            carry_d = ram_rdata;
                        end
                        ram_re    = 1'b1;
                        ram_raddr = idx_q + RAW'(1);
                        phase_d   = CMP;
                    end
                    CMP: begin
                        swap      = desc_q ? (carry_q < ram_rdata) : (carry_q > ram_rdata);
                        ram_we    = 1'b1;
                        ram_waddr = idx_q;
                        ram_wdata = swap ? ram_rdata : carry_q;
                        carry_d   = swap ? carry_q : ram_rdata;
                        if (swap) begin
                            swapped_d = 1'b1;
                        end
                        if ((idx_q + RAW'(1)) == hi_q) begin
                            phase_d = WR;
                        end else begin
                            idx_d   = idx_q + RAW'(1);
                            phase_d = RD_B;
                        end
                    end
                    default: begin
                        ram_we    = 1'b1;
                        ram_waddr = hi_q;
                        ram_wdata = carry_q;
                        if (!swapped_q || (hi_q == RAW'(1))) begin
                            state_d = SEND;
                        end else begin
                            hi_d      = hi_q - RAW'(1);
                            idx_d     = '0;
                            swapped_d = 1'b0;
                            phase_d   = RD_A;
                        end
                    end
                endcase
            end

            default: begin
                // SEND: read data parks in the RAM output register until the output slot frees
                if (pend_q && out_free) begin
                    src_valid_d = 1'b1;
                    src_data_d  = ram_rdata;
                    src_sop_d   = (out_idx_q == '0);
                    src_eop_d   = (out_idx_q == (len_q - AW'(1)));
                    src_err_d   = ovf_q && (out_idx_q == (len_q - AW'(1)));
                    out_idx_d   = out_idx_q + AW'(1);
                end else if (src_fire) begin
                    src_valid_d = 1'b0;
                    src_sop_d   = 1'b0;
                    src_eop_d   = 1'b0;
                    src_err_d   = 1'b0;
                end
                if ((rd_ptr_q < len_q) && (!pend_q || out_free)) begin
                    ram_re    = 1'b1;
                    ram_raddr = rd_ptr_q[RAW-1:0];
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    pend_d    = 1'b1;
                end else if (pend_q && out_free) begin
                    pend_d = 1'b0;
                end
                if (src_fire && src_eop_q) begin
                    state_d = IDLE;
                end
            end
        endcase

        snk_ready_d = (state_d == IDLE) || (state_d == LOAD);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q     <= IDLE;
            phase_q     <= RD_A;
            len_q       <= '0;
            desc_q      <= 1'b0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
            hi_q        <= '0;
            carry_q     <= '0;
            swapped_q   <= 1'b0;
            rd_ptr_q    <= '0;
            out_idx_q   <= '0;
            pend_q      <= 1'b0;
            snk_ready_q <= 1'b1;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            len_q       <= len_d;
            desc_q      <= desc_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            carry_q     <= carry_d;
            swapped_q   <= swapped_d;
            rd_ptr_q    <= rd_ptr_d;
            out_idx_q   <= out_idx_d;
            pend_q      <= pend_d;
            snk_ready_q <= snk_ready_d;
            src_valid_q <= src_valid_d;
            src_data_q  <= src_data_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_err_q   <= src_err_d;
        end
    end

    assign snk_ready_o         = snk_ready_q;
    assign src_valid_o         = src_valid_q;
    assign src_data_o          = src_data_q;
    assign src_startofpacket_o = src_sop_q;
    assign src_endofpacket_o   = src_eop_q;
    assign src_error_o         = src_err_q;

`ifdef SORT_PKT_DIR_STATS_EN
    // Saturating counters of delivered packets and truncated packets
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            stat_pkt_cnt_o <= '0;
            stat_ovf_cnt_o <= '0;
        end else if (src_valid_q && src_ready_i && src_eop_q) begin
            if (~&stat_pkt_cnt_o) begin
                stat_pkt_cnt_o <= stat_pkt_cnt_o + 32'd1;
            end
            if (src_err_q && ~&stat_ovf_cnt_o) begin
                stat_ovf_cnt_o <= stat_ovf_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sort_pkt_dir.md
Name: sort_pkt_dir

Overview:
Successor to the single-direction packet sorter. Buffers one Avalon-ST packet of DWIDTH words, sorts it in place, then streams it out with source backpressure.
Adds per-packet sort direction, oversize-packet truncation with an error flag, and explicit single-word and restart handling.
Sits between a streaming producer and a consumer in the 2.x datapath.

Parameters:
DWIDTH, 8, data word width in bits (≥1)
MAX_PKT_LEN, 1024, buffer depth in words (≥2); AWIDTH = $clog2(MAX_PKT_LEN)+1 is derived, not a parameter

Ports:
clk_i  in  1  single clock
srst_i  in  1  reset, synchronous and active-low (0 = reset)
snk_data_i  in  DWIDTH  input word
snk_startofpacket_i  in  1  first word of packet
snk_endofpacket_i  in  1  last word of packet
snk_valid_i  in  1  input word valid
snk_descend_i  in  1  direction, sampled with the SOP beat; 1 = descending, 0 = ascending
snk_ready_o  out  1  block accepts input
src_ready_i  in  1  consumer ready
src_data_o  out  DWIDTH  output word
src_startofpacket_o  out  1  first output word
src_endofpacket_o  out  1  last output word
src_error_o  out  1  valid with EOP; 1 = input packet was truncated
src_valid_o  out  1  output word valid

Behaviour:
- Reset (srst_i=0 at posedge): FSM goes to IDLE; snk_ready_o=1; all src_* outputs 0; length counter and error flag cleared. Reset mid-operation discards the buffered packet.
- FSM states: IDLE, LOAD, SORT, SEND.
- IDLE:
  - snk_ready_o=1.
  - A beat with valid&sop writes word 0, latches the direction, sets len=1, then:
    - goes to LOAD;
    - if eop is on the same beat, goes straight to SEND with len=1 and SORT is skipped.
  - valid without sop is dropped.
- LOAD:
  - snk_ready_o=1; each valid beat writes at address len and increments len.
  - Beats arriving with len=MAX_PKT_LEN are discarded and set the overflow flag.
  - valid&sop restarts the packet: the word goes to address 0, len=1, direction is re-latched, overflow is cleared.
  - valid&eop goes to SORT; if final len=1, goes to SEND.
- SORT:
  - snk_ready_o=0.
  - Bubble sort with early exit; a pass with no swaps ends the sort.
  - Compare is unsigned. Ascending: swap when a[i]>a[i+1]. Descending: swap when a[i]<a[i+1]. Equal words are never swapped.
  - Completion bound: ≤ 2·len·len + 4 cycles after the EOP beat.
- SEND:
  - snk_ready_o=0. Words are read in address order 0..len-1.
  - First src_valid_o is asserted ≤3 cycles after SEND entry.
  - Avalon-ST rules: while src_valid_o&!src_ready_i, data/sop/eop/error hold stable; a word transfers on valid&ready.
  - src_startofpacket_o is set on word 0. src_endofpacket_o and src_error_o are set on word len-1.
  - After the last transfer, return to IDLE with src_valid_o=0 on the next cycle. The next packet may start in the cycle after that.
- Memory: one-cycle registered read latency; read and write never target the same address in the same cycle.

Optional Feature:
SORT_PKT_DIR_STATS_EN.
- Defined: adds outputs stat_pkt_cnt_o[31:0] and stat_ovf_cnt_o[15:0].
  - stat_pkt_cnt_o increments on every EOP transfer at the source.
  - stat_ovf_cnt_o increments on every EOP transfer with src_error_o=1.
  - Both saturate and both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- sort_pkt_dir_pkg: state enum (IDLE, LOAD, SORT, SEND), sort-phase sub-state enum (RD_A, RD_B, CMP, WR), default DWIDTH and MAX_PKT_LEN constants.
- Sub-module sort_pkt_dir_ram: simple dual-port RAM, depth MAX_PKT_LEN, width DWIDTH, one write and one registered read port, no reset on contents.

Test Plan:
- Ascending, len=111, random data, snk_valid randomly gapped, src_ready=1 → output equals the ascending sort; sop on word 0, eop on word 110, error=0.
- Descending, len=5, data {3,9,1,9,0} → output {9,9,3,1,0}; repeat with snk_descend_i=0 → {0,1,3,9,9}.
- Single word 0xA5 with sop&eop on the same beat → one output beat 0xA5 with sop=eop=1; no SORT cycles.
- len=MAX_PKT_LEN+6 → MAX_PKT_LEN sorted words out from the first MAX_PKT_LEN inputs; error=1 on eop.
- sop re-asserted after 10 words of an unfinished packet, new packet len=4 {4,3,2,1} ascending → output {1,2,3,4}; the first 10 words never appear.
- src_ready toggled randomly during SEND, and srst_i=0 for one cycle mid-SORT → data stable under stall; after reset src_valid_o=0, snk_ready_o=1, and the next packet sorts correctly.
